// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared types and defaults for the GPIO pad ownership arbiter.
//   arb_state_e   - per-pin ownership state (IDLE / JTAG / LOCAL / TURN)
//   NR_GPIOS_DFLT - default number of arbitrated pins
//   MIN_HOLD_DFLT - default minimum local hold time in cycles
//   hold_width()  - width of the hold counter for a given MIN_HOLD
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StJtag  = 2'd1,
    StLocal = 2'd2,
    StTurn  = 2'd3
  } arb_state_e;

  localparam int unsigned NR_GPIOS_DFLT = 3;
  localparam int unsigned MIN_HOLD_DFLT = 1024;

  // $clog2(max_val + 1), but never narrower than one bit.
  function automatic int unsigned hold_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/gpio_owner_arb_if.sv
// gpio_owner_arb_if: request/grant and pad bundle of the GPIO ownership arbiter.
//   jtag_req/jtag_val - JTAG ownership request and drive value per pin
//   loc_req/loc_val   - local logic ownership request and drive value per pin
//   pad_out/pad_oe    - registered pad value and output enable
//   jtag_gnt/loc_gnt  - current owner of each pin
// Modports: master (requesters / pad side view), slave (the arbiter).
interface gpio_owner_arb_if
  import gpio_arb_pkg::*;
#(
  parameter int unsigned NR_GPIOS = NR_GPIOS_DFLT
);

  logic [NR_GPIOS-1:0] jtag_req;
  logic [NR_GPIOS-1:0] jtag_val;
  logic [NR_GPIOS-1:0] loc_req;
  logic [NR_GPIOS-1:0] loc_val;
  logic [NR_GPIOS-1:0] pad_out;
  logic [NR_GPIOS-1:0] pad_oe;
  logic [NR_GPIOS-1:0] jtag_gnt;
  logic [NR_GPIOS-1:0] loc_gnt;

  modport master (
    output jtag_req, jtag_val, loc_req, loc_val,
    input  pad_out, pad_oe, jtag_gnt, loc_gnt
  );

  modport slave (
    input  jtag_req, jtag_val, loc_req, loc_val,
    output pad_out, pad_oe, jtag_gnt, loc_gnt
  );

endinterface

// File: rtl/gpio_arb_pin.sv
// gpio_arb_pin: ownership FSM for a single GPIO pad.
// JTAG beats local on simultaneous requests; local keeps the pin for at least
// MIN_HOLD cycles before JTAG may preempt; every ownership change passes
// through one TURN cycle with the pad tri-stated.
// Ports:
//   clk, reset_        - clock, asynchronous active-low reset
//   jtag_req, jtag_val - JTAG request and drive value (already in clk domain)
//   loc_req, loc_val   - local request and drive value
//   pad_out, pad_oe    - registered pad value / enable
//   jtag_gnt, loc_gnt  - registered ownership flags
module gpio_arb_pin
  import gpio_arb_pkg::*;
#(
  parameter int unsigned MIN_HOLD = MIN_HOLD_DFLT
) (
  input  logic clk,
  input  logic reset_,
  input  logic jtag_req,
  input  logic jtag_val,
  input  logic loc_req,
  input  logic loc_val,
  output logic pad_out,
  output logic pad_oe,
  output logic jtag_gnt,
  output logic loc_gnt
);

  localparam int unsigned HoldW = hold_width(MIN_HOLD);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MIN_HOLD);

  arb_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             pad_out_q, pad_oe_q, jtag_gnt_q, loc_gnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (jtag_req) begin
          state_d = StJtag;
        end else if (loc_req) begin
          state_d = StLocal;
        end
      end
      StJtag: begin
        if (!jtag_req) state_d = StTurn;
      end
      StLocal: begin
        if (!loc_req || (jtag_req && (hold_q == HoldMax))) state_d = StTurn;
      end
      StTurn: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counter is held at zero outside LOCAL, so it starts from zero on every entry.
  always_comb begin
    hold_d = hold_q;
    if (state_q != StLocal) begin
      hold_d = '0;
    end else if (hold_q != HoldMax) begin
      hold_d = hold_q + HoldW'(1);
    end
  end

  // Outputs are loaded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      pad_out_q  <= 1'b0;
      pad_oe_q   <= 1'b0;
      jtag_gnt_q <= 1'b0;
      loc_gnt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      pad_oe_q   <= (state_d == StJtag) || (state_d == StLocal);
      jtag_gnt_q <= (state_d == StJtag);
      loc_gnt_q  <= (state_d == StLocal);
      if (state_d == StJtag) begin
        pad_out_q <= jtag_val;
      end else if (state_d == StLocal) begin
        pad_out_q <= loc_val;
      end else begin
        pad_out_q <= 1'b0;
      end
    end
  end

  assign pad_out  = pad_out_q;
  assign pad_oe   = pad_oe_q;
  assign jtag_gnt = jtag_gnt_q;
  assign loc_gnt  = loc_gnt_q;

endmodule

// File: rtl/gpio_owner_arb.sv
// gpio_owner_arb: per-pin pad ownership arbiter between the JTAG GPIO register
// and on-chip logic. One gpio_arb_pin FSM per pin.
// Ports:
//   clk    - system clock
//   reset_ - asynchronous active-low reset
//   bus    - gpio_owner_arb_if slave: requests/values in, pads and grants out
// Configuration macro GPIO_ARB_SYNC_EN: when defined, jtag_req and jtag_val pass
// through 2-flop synchronizers (TCK-domain source); otherwise they must already
// be synchronous to clk.
module gpio_owner_arb
  import gpio_arb_pkg::*;
#(
  parameter int unsigned NR_GPIOS = NR_GPIOS_DFLT,
  parameter int unsigned MIN_HOLD = MIN_HOLD_DFLT
) (
  input logic             clk,
  input logic             reset_,
  gpio_owner_arb_if.slave bus
);

  logic [NR_GPIOS-1:0] jtag_req_s;
  logic [NR_GPIOS-1:0] jtag_val_s;

`ifdef GPIO_ARB_SYNC_EN
  logic [NR_GPIOS-1:0] req_meta_q, req_sync_q;
  logic [NR_GPIOS-1:0] val_meta_q, val_sync_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      req_meta_q <= '0;
      req_sync_q <= '0;
      val_meta_q <= '0;
      val_sync_q <= '0;
    end else begin
      req_meta_q <= bus.jtag_req;
      req_sync_q <= req_meta_q;
      val_meta_q <= bus.jtag_val;
      val_sync_q <= val_meta_q;
    end
  end

  assign jtag_req_s = req_sync_q;
  assign jtag_val_s = val_sync_q;
`else
  assign jtag_req_s = bus.jtag_req;
  assign jtag_val_s = bus.jtag_val;
`endif

  logic [NR_GPIOS-1:0] pad_out_w;
  logic [NR_GPIOS-1:0] pad_oe_w;
  logic [NR_GPIOS-1:0] jtag_gnt_w;
  logic [NR_GPIOS-1:0] loc_gnt_w;

  for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pin
    gpio_arb_pin #(
      .MIN_HOLD (MIN_HOLD)
    ) u_pin (
      .clk      (clk),
      .reset_   (reset_),
      .jtag_req (jtag_req_s[i]),
      .jtag_val (jtag_val_s[i]),
      .loc_req  (bus.loc_req[i]),
      .loc_val  (bus.loc_val[i]),
      .pad_out  (pad_out_w[i]),
      .pad_oe   (pad_oe_w[i]),
      .jtag_gnt (jtag_gnt_w[i]),
      .loc_gnt  (loc_gnt_w[i])
    );
  end

  assign bus.pad_out  = pad_out_w;
  assign bus.pad_oe   = pad_oe_w;
  assign bus.jtag_gnt = jtag_gnt_w;
  assign bus.loc_gnt  = loc_gnt_w;

endmodule

// File: tb/tb_gpio_owner_arb.sv
// tb_gpio_owner_arb: directed self-checking bench for gpio_owner_arb.
// dut_a uses MIN_HOLD=8, dut_b uses MIN_HOLD=0.
module tb_gpio_owner_arb;

`ifdef GPIO_ARB_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic clk;
  logic reset_;
  int   n_checks;
  int   n_errors;

  gpio_owner_arb_if #(.NR_GPIOS(3)) bus_a ();
  gpio_owner_arb_if #(.NR_GPIOS(3)) bus_b ();

  gpio_owner_arb #(
    .NR_GPIOS (3),
    .MIN_HOLD (8)
  ) dut_a (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus_a)
  );

  gpio_owner_arb #(
    .NR_GPIOS (3),
    .MIN_HOLD (0)
  ) dut_b (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus_a.jtag_req = 3'b000;
    bus_a.loc_req  = 3'b000;
    bus_b.jtag_req = 3'b000;
    bus_b.loc_req  = 3'b000;
    step(SyncLat + 3);
  endtask

  // Local grabs pin p on dut_a, JTAG requests one cycle after the grant; the
  // pin must stay local through hold 1..8 and turn on the following edge.
  task automatic run_preempt_a(input int p, input string tag);
    logic [2:0] m;
    m = 3'b001 << p;
    bus_a.loc_req = m;
    bus_a.loc_val = m;
    step(1);
    check({tag, "_grant"}, 32'(bus_a.loc_gnt), 32'(m));
    check({tag, "_val"}, 32'(bus_a.pad_out), 32'(m));
    bus_a.jtag_req = m;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check({tag, "_held"}, 32'(bus_a.loc_gnt), 32'(m));
    end
    step(1);
    check({tag, "_turn_oe"}, 32'(bus_a.pad_oe), 32'd0);
    check({tag, "_turn_gnt"}, 32'({bus_a.jtag_gnt, bus_a.loc_gnt}), 32'd0);
    step(2);
    check({tag, "_jtag"}, 32'(bus_a.jtag_gnt), 32'(m));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_ = 1'b0;
    bus_a.jtag_req = 3'b111;
    bus_a.jtag_val = 3'b111;
    bus_a.loc_req  = (SyncLat == 0) ? 3'b111 : 3'b000;
    bus_a.loc_val  = 3'b111;
    bus_b.jtag_req = 3'b000;
    bus_b.jtag_val = 3'b000;
    bus_b.loc_req  = 3'b000;
    bus_b.loc_val  = 3'b000;

    // Reset with all requests active
    step(3);
    check("rst_oe", 32'(bus_a.pad_oe), 32'd0);
    check("rst_out", 32'(bus_a.pad_out), 32'd0);
    check("rst_jgnt", 32'(bus_a.jtag_gnt), 32'd0);
    check("rst_lgnt", 32'(bus_a.loc_gnt), 32'd0);
    reset_ = 1'b1;
    #1;
    check("rel_oe", 32'(bus_a.pad_oe), 32'd0);
    step(1 + SyncLat);
    check("rel_jgnt", 32'(bus_a.jtag_gnt), 32'h7);
    check("rel_lgnt", 32'(bus_a.loc_gnt), 32'd0);
    check("rel_out", 32'(bus_a.pad_out), 32'h7);

    // Simultaneous requests on pin 0: JTAG wins
    go_idle();
    check("idle_oe", 32'(bus_a.pad_oe), 32'd0);
    bus_a.jtag_req = 3'b001;
    bus_a.jtag_val = 3'b001;
    bus_a.loc_val  = 3'b000;
    step(SyncLat);
    bus_a.loc_req = 3'b001;
    #1;
    step(1);
    check("sim_jgnt", 32'(bus_a.jtag_gnt), 32'h1);
    check("sim_lgnt", 32'(bus_a.loc_gnt), 32'd0);
    check("sim_out", 32'(bus_a.pad_out), 32'h1);
    check("sim_oe", 32'(bus_a.pad_oe), 32'h1);

    // Turnaround on pin 1: JTAG -> TURN -> IDLE -> LOCAL
    go_idle();
    bus_a.jtag_req = 3'b010;
    bus_a.jtag_val = 3'b010;
    step(1 + SyncLat);
    check("ta_jgnt", 32'(bus_a.jtag_gnt), 32'h2);
    check("ta_jout", 32'(bus_a.pad_out), 32'h2);
    bus_a.loc_req = 3'b010;
    bus_a.loc_val = 3'b000;
    step(1);
    check("ta_ignore_loc", 32'({bus_a.jtag_gnt, bus_a.loc_gnt}), 32'h10);
    bus_a.jtag_req = 3'b000;
    step(1 + SyncLat);
    check("ta_turn_oe", 32'(bus_a.pad_oe), 32'd0);
    check("ta_turn_gnt", 32'({bus_a.jtag_gnt, bus_a.loc_gnt}), 32'd0);
    step(1);
    check("ta_idle_lgnt", 32'(bus_a.loc_gnt), 32'd0);
    step(1);
    check("ta_lgnt", 32'(bus_a.loc_gnt), 32'h2);
    check("ta_loe", 32'(bus_a.pad_oe), 32'h2);
    check("ta_lout", 32'(bus_a.pad_out), 32'd0);

    // Minimum hold = 8 on pin 2
    go_idle();
    run_preempt_a(2, "hold8");

    // Minimum hold = 0 on pin 2: preempted on the next edge
    go_idle();
    bus_b.loc_req = 3'b100;
    bus_b.loc_val = 3'b100;
    bus_b.jtag_val = 3'b000;
    step(1);
    check("hold0_grant", 32'(bus_b.loc_gnt), 32'h4);
    bus_b.jtag_req = 3'b100;
    step(1 + SyncLat);
    check("hold0_turn_oe", 32'(bus_b.pad_oe), 32'd0);
    check("hold0_turn_lgnt", 32'(bus_b.loc_gnt), 32'd0);
    step(2);
    check("hold0_jgnt", 32'(bus_b.jtag_gnt), 32'h4);
    check("hold0_jout", 32'(bus_b.pad_out), 32'd0);

    // Asynchronous reset while pin 0 is local
    go_idle();
    bus_a.loc_req = 3'b001;
    bus_a.loc_val = 3'b001;
    step(1);
    check("ar_lgnt", 32'(bus_a.loc_gnt), 32'h1);
    step(3);
    #3;
    reset_ = 1'b0;
    #1;
    check("ar_oe_async", 32'(bus_a.pad_oe), 32'd0);
    check("ar_lgnt_async", 32'(bus_a.loc_gnt), 32'd0);
    #1;
    reset_ = 1'b1;
    bus_a.loc_req = 3'b000;
    #1;
    // Restart from IDLE with a fresh hold count
    run_preempt_a(0, "ar_hold");

    // Pin independence: pin 0 toggles every cycle
    go_idle();
    bus_a.jtag_req = 3'b010;
    bus_a.jtag_val = 3'b010;
    bus_a.loc_req  = 3'b100;
    bus_a.loc_val  = 3'b000;
    step(1 + SyncLat);
    for (int i = 0; i < 10; i++) begin
      bus_a.jtag_req[0] = i[0];
      bus_a.jtag_val[0] = i[1];
      bus_a.loc_req[0]  = ~i[0];
      bus_a.loc_val[0]  = i[0];
      step(1);
      check("indep", 32'({bus_a.jtag_gnt[2:1], bus_a.loc_gnt[2:1],
                          bus_a.pad_oe[2:1], bus_a.pad_out[2:1]}), 32'h6D);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
